// File: rtl/cprv_pkg.sv
// Shared opcodes, access sizes and LSU state encodings for the cprv core.
package cprv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/cprv_lsu_align.sv
// Lane alignment for the LSU: byte strobes, lane-shifted store data and extended load data.
// CPRV_LSU_MISALIGN_TRAP_EN enables misalignment detection; without it o_misaligned is 0.
module cprv_lsu_align
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
  input  logic [OFF_WIDTH-1:0]  i_req_off,
  input  logic [1:0]            i_req_size,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic [OFF_WIDTH-1:0]  i_rsp_off,
  input  logic [2:0]            i_rsp_funct3,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_misaligned,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_ld_data
);

  logic [3:0]            w_req_bytes;
  logic [STRB_WIDTH-1:0] w_req_mask;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [6:0]            w_rsp_bits;
  logic                  w_sign;
  logic                  w_fill;

  assign w_req_bytes = size_bytes(mem_size_e'(i_req_size));

  // Mask is built at bus width, so a shifted mask wraps off the top of the bus.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_mask
      assign w_req_mask[gi] = (4'(gi) < w_req_bytes);
    end
  endgenerate

  assign o_wstrb = w_req_mask << i_req_off;
  assign o_wdata = i_rs2 << {i_req_off, 3'b000};

`ifdef CPRV_LSU_MISALIGN_TRAP_EN
  assign o_misaligned = (|(i_req_off & OFF_WIDTH'(w_req_bytes - 4'd1))) ||
                        ((DATA_WIDTH == 32) && (i_req_size == 2'd3));
`else
  assign o_misaligned = 1'b0;
`endif

  assign w_lane     = i_rdata >> {i_rsp_off, 3'b000};
  assign w_rsp_bits = {size_bytes(mem_size_e'(i_rsp_funct3[1:0])), 3'b000};

  always_comb begin
    w_sign = 1'b0;
    unique case (mem_size_e'(i_rsp_funct3[1:0]))
      MEM_B:   w_sign = w_lane[7];
      MEM_H:   w_sign = w_lane[15];
      MEM_W:   w_sign = w_lane[31];
      default: w_sign = w_lane[DATA_WIDTH-1];
    endcase
  end

  assign w_fill = w_sign & ~i_rsp_funct3[2];

  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
      assign o_ld_data[gi] = (7'(gi) < w_rsp_bits) ? w_lane[gi] : w_fill;
    end
  endgenerate

endmodule

// File: rtl/cprv_lsu_stage.sv
// Memory stage between ex and wb: sizes, aligns and issues dmem accesses, extends load data.
// Define CPRV_LSU_MISALIGN_TRAP_EN to retire misaligned accesses without a dmem request.
module cprv_lsu_stage
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  input  logic                  mem_w_en_mem_i,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] mem_data_wb_o,
  output logic                  misalign_wb_o,
  output logic                  valid_dmem_o,
  input  logic                  ready_dmem_i,
  output logic [DATA_WIDTH-1:0] addr_dmem_o,
  output logic [DATA_WIDTH-1:0] wdata_dmem_o,
  output logic [STRB_WIDTH-1:0] wstrb_dmem_o,
  output logic                  w_en_dmem_o,
  input  logic                  valid_mem_dmem_i,
  output logic                  ready_mem_dmem_o,
  input  logic [DATA_WIDTH-1:0] rdata_dmem_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_next;

  logic                  r_valid_wb;
  logic [4:0]            r_rd_addr_wb;
  logic                  r_rd_en_wb;
  logic [6:0]            r_opcode_wb;
  logic [2:0]            r_funct3_wb;
  logic [DATA_WIDTH-1:0] r_alu_out_wb;
  logic [DATA_WIDTH-1:0] r_mem_data_wb;
  logic                  r_misalign_wb;

  logic                  r_valid_dmem;
  logic [DATA_WIDTH-1:0] r_addr_dmem;
  logic [DATA_WIDTH-1:0] r_wdata_dmem;
  logic [STRB_WIDTH-1:0] r_wstrb_dmem;
  logic                  r_w_en_dmem;

  logic                  w_wb_free;
  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_is_mem;
  logic                  w_misaligned;
  logic                  w_trap;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_capture;
  logic                  w_issue;
  logic                  w_ld_capture;
  logic                  w_valid_wb_next;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_wb_free        = ~r_valid_wb | ready_wb_i;
  assign ready_mem_o      = (r_state == IDLE) & w_wb_free;
  assign w_accept         = valid_mem_i & ready_mem_o;
  assign w_is_load        = (opcode_mem_i == OP_LOAD);
  assign w_is_store       = (opcode_mem_i == OP_STORE) & mem_w_en_mem_i;
  assign w_is_mem         = w_is_load | w_is_store;
  assign w_trap           = w_is_mem & w_misaligned;
  assign ready_mem_dmem_o = (r_state == RESP) & w_wb_free;
  assign w_req_fire       = r_valid_dmem & ready_dmem_i;
  assign w_rsp_fire       = valid_mem_dmem_i & ready_mem_dmem_o;

  // Response side aligns against the op parked in the wb register while the access is in flight.
  cprv_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .OFF_WIDTH  (OFF_WIDTH)
  ) u_align (
    .i_req_off    (alu_out_mem_i[OFF_WIDTH-1:0]),
    .i_req_size   (funct3_mem_i[1:0]),
    .i_rs2        (rs2_data_mem_i),
    .i_rsp_off    (r_alu_out_wb[OFF_WIDTH-1:0]),
    .i_rsp_funct3 (r_funct3_wb),
    .i_rdata      (rdata_dmem_i),
    .o_misaligned (w_misaligned),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_capture       = 1'b0;
    w_issue         = 1'b0;
    w_ld_capture    = 1'b0;
    w_valid_wb_next = r_valid_wb & ~ready_wb_i;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_capture = 1'b1;
          if (w_is_mem && !w_trap) begin
            w_issue      = 1'b1;
            w_state_next = REQ;
          end else begin
            w_valid_wb_next = 1'b1;
          end
        end
      end
      REQ: begin
        // Stores retire on request acceptance; only loads wait for data.
        if (w_req_fire) begin
          if (r_w_en_dmem) begin
            w_state_next    = IDLE;
            w_valid_wb_next = 1'b1;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      RESP: begin
        if (w_rsp_fire) begin
          w_state_next    = IDLE;
          w_valid_wb_next = 1'b1;
          w_ld_capture    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_dmem <= 1'b0;
      r_addr_dmem  <= '0;
      r_wdata_dmem <= '0;
      r_wstrb_dmem <= '0;
      r_w_en_dmem  <= 1'b0;
    end else if (w_issue) begin
      r_valid_dmem <= 1'b1;
      r_addr_dmem  <= {alu_out_mem_i[DATA_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
      r_wdata_dmem <= w_wdata;
      r_wstrb_dmem <= w_is_store ? w_wstrb : '0;
      r_w_en_dmem  <= w_is_store;
    end else if (w_req_fire) begin
      r_valid_dmem <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_wb    <= 1'b0;
      r_rd_addr_wb  <= '0;
      r_rd_en_wb    <= 1'b0;
      r_opcode_wb   <= '0;
      r_funct3_wb   <= '0;
      r_alu_out_wb  <= '0;
      r_mem_data_wb <= '0;
      r_misalign_wb <= 1'b0;
    end else begin
      r_valid_wb <= w_valid_wb_next;
      if (w_capture) begin
        r_rd_addr_wb  <= rd_addr_mem_i;
        r_rd_en_wb    <= rd_en_mem_i & ~w_trap;
        r_opcode_wb   <= opcode_mem_i;
        r_funct3_wb   <= funct3_mem_i;
        r_alu_out_wb  <= alu_out_mem_i;
        r_mem_data_wb <= '0;
        r_misalign_wb <= w_trap;
      end else if (w_ld_capture) begin
        r_mem_data_wb <= w_ld_data;
      end
    end
  end

  assign valid_wb_o    = r_valid_wb;
  assign rd_addr_wb_o  = r_rd_addr_wb;
  assign rd_en_wb_o    = r_rd_en_wb;
  assign opcode_wb_o   = r_opcode_wb;
  assign funct3_wb_o   = r_funct3_wb;
  assign alu_out_wb_o  = r_alu_out_wb;
  assign mem_data_wb_o = r_mem_data_wb;
  assign misalign_wb_o = r_misalign_wb;
  assign valid_dmem_o  = r_valid_dmem;
  assign addr_dmem_o   = r_addr_dmem;
  assign wdata_dmem_o  = r_wdata_dmem;
  assign wstrb_dmem_o  = r_wstrb_dmem;
  assign w_en_dmem_o   = r_w_en_dmem;

endmodule

// File: tb/tb_cprv_lsu_stage.sv
// Directed bench for cprv_lsu_stage: vector table of single ops plus stall, throughput and reset sequences.
`timescale 1ns/1ps
module tb_cprv_lsu_stage;
  import cprv_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem_i;
  logic        ready_mem_o;
  logic [63:0] rs2_data_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        rd_en_mem_i;
  logic [6:0]  opcode_mem_i;
  logic [2:0]  funct3_mem_i;
  logic        mem_w_en_mem_i;
  logic [63:0] alu_out_mem_i;
  logic        valid_wb_o;
  logic        ready_wb_i;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [2:0]  funct3_wb_o;
  logic [63:0] alu_out_wb_o;
  logic [63:0] mem_data_wb_o;
  logic        misalign_wb_o;
  logic        valid_dmem_o;
  logic        ready_dmem_i;
  logic [63:0] addr_dmem_o;
  logic [63:0] wdata_dmem_o;
  logic [7:0]  wstrb_dmem_o;
  logic        w_en_dmem_o;
  logic        valid_mem_dmem_i;
  logic        ready_mem_dmem_o;
  logic [63:0] rdata_dmem_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cprv_lsu_stage #(.DATA_WIDTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_mem_i      (valid_mem_i),
    .ready_mem_o      (ready_mem_o),
    .rs2_data_mem_i   (rs2_data_mem_i),
    .rd_addr_mem_i    (rd_addr_mem_i),
    .rd_en_mem_i      (rd_en_mem_i),
    .opcode_mem_i     (opcode_mem_i),
    .funct3_mem_i     (funct3_mem_i),
    .mem_w_en_mem_i   (mem_w_en_mem_i),
    .alu_out_mem_i    (alu_out_mem_i),
    .valid_wb_o       (valid_wb_o),
    .ready_wb_i       (ready_wb_i),
    .rd_addr_wb_o     (rd_addr_wb_o),
    .rd_en_wb_o       (rd_en_wb_o),
    .opcode_wb_o      (opcode_wb_o),
    .funct3_wb_o      (funct3_wb_o),
    .alu_out_wb_o     (alu_out_wb_o),
    .mem_data_wb_o    (mem_data_wb_o),
    .misalign_wb_o    (misalign_wb_o),
    .valid_dmem_o     (valid_dmem_o),
    .ready_dmem_i     (ready_dmem_i),
    .addr_dmem_o      (addr_dmem_o),
    .wdata_dmem_o     (wdata_dmem_o),
    .wstrb_dmem_o     (wstrb_dmem_o),
    .w_en_dmem_o      (w_en_dmem_o),
    .valid_mem_dmem_i (valid_mem_dmem_i),
    .ready_mem_dmem_o (ready_mem_dmem_o),
    .rdata_dmem_i     (rdata_dmem_i)
  );

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        w_en;
    logic        rd_en;
    logic [63:0] rs2;
    logic [63:0] addr;
    logic [63:0] rdata;
    int          exp_lat;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_mem;
    logic        exp_mis;
    logic        exp_rd_en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic wen, input logic rden,
                              input logic [63:0] rs2, input logic [63:0] addr, input logic [63:0] rdata,
                              input int lat, input logic req,
                              input logic [63:0] eaddr, input logic [63:0] ewdata,
                              input logic [7:0] ewstrb, input logic [63:0] emem,
                              input logic emis, input logic erden);
    vec_t v;
    v.name = name; v.opcode = op; v.funct3 = f3; v.w_en = wen; v.rd_en = rden;
    v.rs2 = rs2; v.addr = addr; v.rdata = rdata; v.exp_lat = lat; v.exp_req = req;
    v.exp_addr = eaddr; v.exp_wdata = ewdata; v.exp_wstrb = ewstrb; v.exp_mem = emem;
    v.exp_mis = emis; v.exp_rd_en = erden;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single op with an always-ready dmem that answers a load one cycle after the request fires.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit pend;
    bit req_seen;
    lat = -1; pend = 0; req_seen = 0;
    check({v.name, ".ready_mem"}, 64'(ready_mem_o), 64'd1);
    valid_mem_i = 1'b1; opcode_mem_i = v.opcode; funct3_mem_i = v.funct3;
    mem_w_en_mem_i = v.w_en; rd_en_mem_i = v.rd_en; rs2_data_mem_i = v.rs2;
    alu_out_mem_i = v.addr; rd_addr_mem_i = 5'(idx);
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      valid_mem_dmem_i = pend;
      rdata_dmem_i = pend ? v.rdata : 64'd0;
      pend = 0;
      if (valid_wb_o) begin
        lat = k;
        check({v.name, ".rd_addr"},  64'(rd_addr_wb_o),  64'(idx));
        check({v.name, ".rd_en"},    64'(rd_en_wb_o),    64'(v.exp_rd_en));
        check({v.name, ".opcode"},   64'(opcode_wb_o),   64'(v.opcode));
        check({v.name, ".funct3"},   64'(funct3_wb_o),   64'(v.funct3));
        check({v.name, ".alu_out"},  alu_out_wb_o,       v.addr);
        check({v.name, ".mem_data"}, mem_data_wb_o,      v.exp_mem);
        check({v.name, ".misalign"}, 64'(misalign_wb_o), 64'(v.exp_mis));
        break;
      end
      if (valid_dmem_o && !req_seen) begin
        req_seen = 1;
        check({v.name, ".addr_dmem"},  addr_dmem_o,       v.exp_addr);
        check({v.name, ".wdata_dmem"}, wdata_dmem_o,      v.exp_wdata);
        check({v.name, ".wstrb_dmem"}, 64'(wstrb_dmem_o), 64'(v.exp_wstrb));
        check({v.name, ".w_en_dmem"},  64'(w_en_dmem_o),  64'(v.w_en));
      end
      if (valid_dmem_o && ready_dmem_i && !w_en_dmem_o) pend = 1;
      @(posedge clk); #1;
    end
    valid_mem_dmem_i = 1'b0;
    check({v.name, ".latency"},  64'(lat),      64'(v.exp_lat));
    check({v.name, ".req_seen"}, 64'(req_seen), 64'(v.exp_req));
    $display("[TB] vec %0d %s lat=%0d mem_data=%h", idx, v.name, lat, mem_data_wb_o);
  endtask

  localparam logic [63:0] RD1 = 64'h1122_8044_F566_7788;
  localparam logic [63:0] RD2 = 64'hF0E1_D2C3_B4A5_9687;

  initial begin
    int in_i;
    int out_i;

    vecs.push_back(mk("alu", OP_ALU, 3'd0, 0, 1, 64'h55, 64'hDEAD_BEEF_0000_1234, 0,
                      1, 0, 0, 0, 8'h00, 64'd0, 0, 1));
    vecs.push_back(mk("sd", OP_STORE, 3'd3, 1, 0, 64'h1122_3344_5566_7788, 64'h1000, 0,
                      2, 1, 64'h1000, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0, 0));
    vecs.push_back(mk("sb", OP_STORE, 3'd0, 1, 0, 64'hAB, 64'h1003, 0,
                      2, 1, 64'h1000, 64'h0000_0000_AB00_0000, 8'h08, 64'd0, 0, 0));
    vecs.push_back(mk("sh", OP_STORE, 3'd1, 1, 0, 64'h1234_5678_9ABC_BEEF, 64'h2006, 0,
                      2, 1, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'd0, 0, 0));
    vecs.push_back(mk("sw", OP_STORE, 3'd2, 1, 0, 64'hCAFE_BABE, 64'h3004, 0,
                      2, 1, 64'h3000, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'd0, 0, 0));
    vecs.push_back(mk("lb", OP_LOAD, 3'd0, 0, 1, 0, 64'h2005, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 0, 1));
    vecs.push_back(mk("lbu", OP_LOAD, 3'd4, 0, 1, 0, 64'h2005, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'h80, 0, 1));
    vecs.push_back(mk("lh", OP_LOAD, 3'd1, 0, 1, 0, 64'h2002, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_FFFF_F566, 0, 1));
    vecs.push_back(mk("lhu", OP_LOAD, 3'd5, 0, 1, 0, 64'h2002, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'hF566, 0, 1));
    vecs.push_back(mk("lw_lo", OP_LOAD, 3'd2, 0, 1, 0, 64'h2000, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_F566_7788, 0, 1));
    vecs.push_back(mk("lwu", OP_LOAD, 3'd6, 0, 1, 0, 64'h2000, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'hF566_7788, 0, 1));
    vecs.push_back(mk("lw_hi", OP_LOAD, 3'd2, 0, 1, 0, 64'h2004, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'h1122_8044, 0, 1));
    vecs.push_back(mk("ld", OP_LOAD, 3'd3, 0, 1, 0, 64'h2008, RD2,
                      3, 1, 64'h2008, 0, 8'h00, RD2, 0, 1));
`ifdef CPRV_LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lh_mis", OP_LOAD, 3'd1, 0, 1, 0, 64'h2001, RD1,
                      1, 0, 0, 0, 8'h00, 64'd0, 1, 0));
    vecs.push_back(mk("sw_mis", OP_STORE, 3'd2, 1, 0, 64'hCAFE_BABE, 64'h1006, 0,
                      1, 0, 0, 0, 8'h00, 64'd0, 1, 0));
`else
    vecs.push_back(mk("lh_mis", OP_LOAD, 3'd1, 0, 1, 0, 64'h2001, RD1,
                      3, 1, 64'h2000, 0, 8'h00, 64'h6677, 0, 1));
    vecs.push_back(mk("sw_mis", OP_STORE, 3'd2, 1, 0, 64'hCAFE_BABE, 64'h1006, 0,
                      2, 1, 64'h1000, 64'hBABE_0000_0000_0000, 8'hC0, 64'd0, 0, 0));
`endif

    rst = 1'b1; valid_mem_i = 1'b0; rs2_data_mem_i = '0; rd_addr_mem_i = '0; rd_en_mem_i = 1'b0;
    opcode_mem_i = '0; funct3_mem_i = '0; mem_w_en_mem_i = 1'b0; alu_out_mem_i = '0;
    ready_wb_i = 1'b1; ready_dmem_i = 1'b1; valid_mem_dmem_i = 1'b0; rdata_dmem_i = '0;

    #12;
    check("rst.valid_wb",      64'(valid_wb_o),       64'd0);
    check("rst.valid_dmem",    64'(valid_dmem_o),     64'd0);
    check("rst.ready_mem_dmem", 64'(ready_mem_dmem_o), 64'd0);
    check("rst.misalign",      64'(misalign_wb_o),    64'd0);
    check("rst.w_en_dmem",     64'(w_en_dmem_o),      64'd0);
    check("rst.mem_data",      mem_data_wb_o,         64'd0);
    check("rst.addr_dmem",     addr_dmem_o,           64'd0);
    check("rst.ready_mem",     64'(ready_mem_o),      64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Load with a stalled dmem request and a delayed response; a stray response in REQ is ignored.
    ready_dmem_i = 1'b0;
    valid_mem_i = 1'b1; opcode_mem_i = OP_LOAD; funct3_mem_i = 3'd2; mem_w_en_mem_i = 1'b0;
    rd_en_mem_i = 1'b1; rs2_data_mem_i = '0; alu_out_mem_i = 64'h2004; rd_addr_mem_i = 5'd20;
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      valid_mem_dmem_i = (k == 2);
      rdata_dmem_i = 64'hDEAD_DEAD_DEAD_DEAD;
      check("stall.valid_dmem", 64'(valid_dmem_o), 64'd1);
      check("stall.addr_dmem",  addr_dmem_o,       64'h2000);
      check("stall.wstrb",      64'(wstrb_dmem_o), 64'd0);
      check("stall.ready_mem",  64'(ready_mem_o),  64'd0);
      if (k == 2) check("stall.stray_rsp_ready", 64'(ready_mem_dmem_o), 64'd0);
      $display("[TB] stall cycle %0d valid_dmem=%0b addr=%h", k, valid_dmem_o, addr_dmem_o);
      @(posedge clk); #1;
    end
    valid_mem_dmem_i = 1'b0;
    ready_dmem_i = 1'b1;
    check("stall.held_valid_dmem", 64'(valid_dmem_o), 64'd1);
    @(posedge clk); #1;
    ready_dmem_i = 1'b0;
    check("stall.resp_wait_valid_dmem", 64'(valid_dmem_o),     64'd0);
    check("stall.resp_ready",          64'(ready_mem_dmem_o), 64'd1);
    check("stall.resp_wait_ready_mem", 64'(ready_mem_o),      64'd0);
    @(posedge clk); #1;
    valid_mem_dmem_i = 1'b1; rdata_dmem_i = 64'h8000_0001_0000_0000;
    check("stall.no_early_wb", 64'(valid_wb_o), 64'd0);
    @(posedge clk); #1;
    valid_mem_dmem_i = 1'b0; rdata_dmem_i = '0;
    check("stall.wb_valid", 64'(valid_wb_o),   64'd1);
    check("stall.mem_data", mem_data_wb_o,     64'hFFFF_FFFF_8000_0001);
    check("stall.rd_addr",  64'(rd_addr_wb_o), 64'd20);
    ready_wb_i = 1'b0;
    @(posedge clk); #1;
    check("hold.wb_valid",  64'(valid_wb_o),  64'd1);
    check("hold.mem_data",  mem_data_wb_o,    64'hFFFF_FFFF_8000_0001);
    check("hold.ready_mem", 64'(ready_mem_o), 64'd0);
    ready_wb_i = 1'b1;
    #1;
    check("hold.ready_mem_release", 64'(ready_mem_o), 64'd1);
    @(posedge clk); #1;
    check("hold.wb_drained", 64'(valid_wb_o), 64'd0);
    $display("[TB] stalled lw done mem_data=%h", mem_data_wb_o);
    ready_dmem_i = 1'b1;

    // Back-to-back ALU ops with wb ready toggling 1,0,1.
    in_i = 0; out_i = 0;
    for (int c = 0; c < 40 && out_i < 6; c++) begin
      ready_wb_i = ((c % 3) != 1);
      valid_mem_i = (in_i < 6); opcode_mem_i = OP_ALU; funct3_mem_i = 3'd0; mem_w_en_mem_i = 1'b0;
      rd_en_mem_i = 1'b1; alu_out_mem_i = 64'h100 + 64'(in_i); rd_addr_mem_i = 5'(in_i);
      #1;
      if (valid_wb_o && ready_wb_i) begin
        check("b2b.alu_out", alu_out_wb_o,       64'h100 + 64'(out_i));
        check("b2b.rd_addr", 64'(rd_addr_wb_o),  64'(out_i));
        $display("[TB] b2b out %0d alu_out=%h", out_i, alu_out_wb_o);
        out_i++;
      end
      if (valid_mem_i && ready_mem_o) in_i++;
      @(posedge clk); #1;
    end
    valid_mem_i = 1'b0; ready_wb_i = 1'b1;
    check("b2b.count", 64'(out_i), 64'd6);
    @(posedge clk); #1;
    check("b2b.no_dup", 64'(valid_wb_o), 64'd0);

    // Reset while a store request is pending.
    ready_dmem_i = 1'b0;
    valid_mem_i = 1'b1; opcode_mem_i = OP_STORE; funct3_mem_i = 3'd3; mem_w_en_mem_i = 1'b1;
    rd_en_mem_i = 1'b0; rs2_data_mem_i = 64'h0123_4567_89AB_CDEF; alu_out_mem_i = 64'h1000;
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
    check("rstreq.valid_dmem_before", 64'(valid_dmem_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstreq.valid_dmem", 64'(valid_dmem_o), 64'd0);
    check("rstreq.wstrb",      64'(wstrb_dmem_o), 64'd0);
    check("rstreq.addr_dmem",  addr_dmem_o,       64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rstreq.idle_ready", 64'(ready_mem_o),  64'd1);
    check("rstreq.no_replay",  64'(valid_dmem_o), 64'd0);
    $display("[TB] reset in REQ handled valid_dmem=%0b", valid_dmem_o);
    ready_dmem_i = 1'b1;
    run_vec(0, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cprv_lsu_stage.md
Name: cprv_lsu_stage

Overview:
Parametrised memory stage between ex and wb.
- Sizes loads and stores by funct3 (byte, half, word, double).
- Generates byte strobes and lane-shifted write data.
- Sign- or zero-extends load data.
- Decouples the dmem request and response channels with a small FSM.
- Fixes the old store behaviour: a store completes on request acceptance and never waits for a dmem response.

Parameters:
DATA_WIDTH, 64, datapath and dmem bus width; 32 or 64.
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width (derived; not overridden).
OFF_WIDTH, $clog2(DATA_WIDTH/8), address lane-offset bits (derived).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_mem_i  in  1  ex→mem valid
ready_mem_o  out  1  mem→ex ready
rs2_data_mem_i  in  DATA_WIDTH  store source
rd_addr_mem_i  in  5  destination register
rd_en_mem_i  in  1  register write enable
opcode_mem_i  in  7  opcode
funct3_mem_i  in  3  access size [1:0], unsigned flag [2]
mem_w_en_mem_i  in  1  store qualifier
alu_out_mem_i  in  DATA_WIDTH  effective address / ALU result
valid_wb_o  out  1  mem→wb valid
ready_wb_i  in  1  wb ready
rd_addr_wb_o  out  5  registered rd_addr
rd_en_wb_o  out  1  registered rd_en; forced 0 on a misaligned access
opcode_wb_o  out  7  registered opcode
funct3_wb_o  out  3  registered funct3
alu_out_wb_o  out  DATA_WIDTH  registered alu_out
mem_data_wb_o  out  DATA_WIDTH  extended load data; 0 for non-loads
misalign_wb_o  out  1  access was misaligned (macro-gated)
valid_dmem_o  out  1  dmem request valid
ready_dmem_i  in  1  dmem request ready
addr_dmem_o  out  DATA_WIDTH  address, low OFF_WIDTH bits cleared
wdata_dmem_o  out  DATA_WIDTH  lane-shifted store data
wstrb_dmem_o  out  STRB_WIDTH  byte strobes; all 0 for loads
w_en_dmem_o  out  1  1 = store
valid_mem_dmem_i  in  1  dmem response valid
ready_mem_dmem_o  out  1  response ready
rdata_dmem_i  in  DATA_WIDTH  response data

Behaviour:
- Reset (async): state IDLE. valid_wb_o, valid_dmem_o, ready_mem_dmem_o, misalign_wb_o, w_en_dmem_o = 0. All data outputs = 0.
- wb_free = ~valid_wb_o | ready_wb_i.
- ready_mem_o = (state==IDLE) & wb_free.
- Transfer happens when valid & ready on the same cycle.
- FSM states: IDLE, REQ, RESP.
- IDLE, accepted non-memory op: wb register loads; valid_wb_o=1 next cycle. Throughput 1/cycle.
- IDLE, accepted LOAD/STORE:
  - Aligned → go to REQ; valid_dmem_o=1 next cycle; wb register loads valid=0.
  - Misaligned → see Optional Feature.
- REQ: valid_dmem_o and all request fields are held stable until ready_dmem_i.
  - On acceptance of a STORE → IDLE; valid_wb_o=1 next cycle.
  - On acceptance of a LOAD → RESP.
- RESP: ready_mem_dmem_o = wb_free. On response handshake → IDLE; mem_data_wb_o is the extended lane; valid_wb_o=1 next cycle.
- A response arriving outside RESP is ignored (ready_mem_dmem_o=0).
- Minimum latency, with accept at cycle T:
  - non-memory op: wb valid at T+1.
  - STORE: wb valid at T+2.
  - LOAD, with a 1-cycle dmem: wb valid at T+3.
- Alignment: off = alu_out[OFF_WIDTH-1:0]; bytes = 1<<funct3[1:0]. Misaligned if off % bytes != 0.
- funct3[1:0]=3 with DATA_WIDTH=32 is treated as misaligned.
- Store data: wdata = rs2 << (off*8). wstrb = ((1<<bytes)-1) << off.
- Load data: lane = rdata >> (off*8), truncated to bytes×8 bits. It is sign-extended when funct3[2]=0 and zero-extended otherwise.
- valid_wb_o is held while ~ready_wb_i; all wb fields stay stable.
- Reset mid-transaction: the FSM returns to IDLE immediately and the pending request is dropped.

Optional Feature:
Macro CPRV_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no dmem request. The wb register loads the op with misalign_wb_o=1, rd_en_wb_o=0 and mem_data_wb_o=0. valid_wb_o=1 at T+1.
- Undefined: misalign_wb_o is tied to 0. The access is issued with strobes and lanes computed modulo STRB_WIDTH (bits above the bus are discarded).

Decomposition:
- Package cprv_pkg holds:
  - LOAD/STORE opcode constants.
  - mem_size_e enum (B, H, W, D).
  - lsu_state_e enum (IDLE, REQ, RESP).
- Sub-module cprv_lsu_align (combinational) computes off, misaligned, wstrb, shifted wdata and the extended load lane.

Test Plan:
- SD with rs2=0x1122334455667788, addr=0x1000, ready_dmem_i=1 → wstrb=0xFF, wdata unchanged, addr_dmem_o=0x1000, wb valid at T+2.
- SB with rs2=0xAB, addr=0x1003 → wstrb=0x08, wdata=0x00000000AB000000; no response is awaited.
- LB at addr 0x2005 with rdata byte5=0x80 → mem_data=0xFFFFFFFFFFFFFF80. LBU with the same data → 0x80.
- LW with ready_dmem_i held low 3 cycles, then a response 2 cycles later → request stable throughout; ready_mem_o=0 until wb valid.
- LH at addr 0x2001 with the macro defined → no valid_dmem_o; misalign_wb_o=1; rd_en_wb_o=0.
- Back-to-back ALU ops with ready_wb_i toggling 1,0,1 → no loss or duplication; rst asserted in REQ → valid_dmem_o=0 the same cycle.
